// File: rtl/branch_pkg.sv
// Shared types and default widths for the execute-stage branch resolver.
package branch_pkg;

  localparam int unsigned DEF_XLEN  = 32;
  localparam int unsigned DEF_CNT_W = 32;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_RSV2 = 3'b010,
    F3_RSV3 = 3'b011,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition decode from comparator flags and funct3.
module br_cond_eval
  import branch_pkg::*;
(
  input  logic       i_is_branch,
  input  logic [2:0] i_funct3,
  input  logic       i_less,
  input  logic       i_equal,
  output logic       o_taken_c,
  output logic       o_illegal_c,
  output logic       o_unsigned_c
);

  assign o_unsigned_c = i_is_branch & i_funct3[1];

  always_comb begin
    o_taken_c   = 1'b0;
    o_illegal_c = 1'b0;
    case (funct3_e'(i_funct3))
      F3_BEQ:           o_taken_c = i_equal;
      F3_BNE:           o_taken_c = ~i_equal;
      F3_BLT, F3_BLTU:  o_taken_c = i_less;
      F3_BGE, F3_BGEU:  o_taken_c = ~i_less;
      default:          o_illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch/jump resolver with registered redirect and flush handshake.
// Define BR_PERF_CNT_EN to add saturating branch/taken/mispredict counters.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int unsigned XLEN  = DEF_XLEN
`ifdef BR_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W = DEF_CNT_W
`endif
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_is_branch,
  input  logic            i_is_jal,
  input  logic            i_is_jalr,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic            i_pred_taken,
  input  logic [XLEN-1:0] i_pred_pc,
  output logic            o_br_unsigned,
  input  logic            i_br_less,
  input  logic            i_br_equal,
  output logic            o_redirect_valid,
  input  logic            i_redirect_ready,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_flush,
  output logic [XLEN-1:0] o_link_pc,
  output logic            o_illegal
`ifdef BR_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_taken_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
`endif
);

  logic cond_taken, cond_illegal;

  br_cond_eval u_cond (
    .i_is_branch  (i_is_branch),
    .i_funct3     (i_funct3),
    .i_less       (i_br_less),
    .i_equal      (i_br_equal),
    .o_taken_c    (cond_taken),
    .o_illegal_c  (cond_illegal),
    .o_unsigned_c (o_br_unsigned)
  );

  state_e          state_q, state_d;
  logic            rv_q, rv_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  logic            flush_q, flush_d;
  logic [XLEN-1:0] link_q, link_d;
  logic            ill_q, ill_d;

  logic            is_jump, is_cf, accept, taken, mispred;
  logic [XLEN-1:0] pc_plus4, target, next_pc;

  // Target and prediction check; JALR target has bit 0 cleared.
  assign is_jump  = i_is_jal | i_is_jalr;
  assign is_cf    = i_is_branch | is_jump;
  assign o_ready  = (state_q == IDLE);
  assign accept   = i_valid & o_ready;
  assign pc_plus4 = i_pc + XLEN'(4);
  assign target   = i_is_jalr ? ((i_rs1_data + i_imm) & {{(XLEN-1){1'b1}}, 1'b0})
                              : (i_pc + i_imm);
  assign taken    = is_jump | (i_is_branch & cond_taken);
  assign next_pc  = taken ? target : pc_plus4;
  assign mispred  = (taken != i_pred_taken) | (taken & (target != i_pred_pc));

  always_comb begin
    state_d = state_q;
    rv_d    = rv_q;
    rpc_d   = rpc_q;
    flush_d = 1'b0;
    link_d  = link_q;
    ill_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && is_cf) begin
          if (is_jump) link_d = pc_plus4;
          ill_d = i_is_branch & ~is_jump & cond_illegal;
          if (mispred) begin
            rv_d    = 1'b1;
            rpc_d   = next_pc;
            flush_d = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (i_redirect_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      flush_q <= 1'b0;
      link_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
      flush_q <= flush_d;
      link_q  <= link_d;
      ill_q   <= ill_d;
    end
  end

  assign o_redirect_valid = rv_q;
  assign o_redirect_pc    = rpc_q;
  assign o_flush          = flush_q;
  assign o_link_pc        = link_q;
  assign o_illegal        = ill_q;

`ifdef BR_PERF_CNT_EN
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, tk_cnt_q, tk_cnt_d, mp_cnt_q, mp_cnt_d;
  logic             cnt_en;

  // Saturating event counters over accepted branch/jump instructions.
  assign cnt_en = accept & is_cf;

  always_comb begin
    br_cnt_d = br_cnt_q;
    tk_cnt_d = tk_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (cnt_en) begin
      if (!(&br_cnt_q))            br_cnt_d = br_cnt_q + CNT_W'(1);
      if (taken && !(&tk_cnt_q))   tk_cnt_d = tk_cnt_q + CNT_W'(1);
      if (mispred && !(&mp_cnt_q)) mp_cnt_d = mp_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign o_br_cnt      = br_cnt_q;
  assign o_taken_cnt   = tk_cnt_q;
  assign o_mispred_cnt = mp_cnt_q;
`endif

endmodule
